// File: rtl/seq_alu.sv
// Handshaked ALU with registered Z/N/C/V flags. Single-cycle logic/arith/shift ops,
// plus iterative shift-add multiply and restoring unsigned divide (WIDTH iterations each).
module seq_alu #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [3:0]               aluop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     Z,
  output logic                     N,
  output logic                     C,
  output logic                     V
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NAND, OP_XOR, OP_LSL, OP_LSR,
    OP_PASSB, OP_ASR, OP_MUL, OP_UDIV
  } alu_op_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic             is_div_q, dz_q;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q, rem_q;
  logic [WIDTH-1:0] result_q;
  logic             z_q, n_q, c_q, v_q;

  logic             accept, multi, last;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  logic [WIDTH-1:0] acc_nx, rem_nx, quo_nx, diff, fin_res;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;

  assign accept = in_valid && (state_q == S_IDLE);
  assign multi  = (aluop == OP_MUL) || (aluop == OP_UDIV);
  assign last   = (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    case (state_q)
      S_IDLE: if (in_valid) state_d = multi ? S_BUSY : S_DONE;
      S_BUSY: if (last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum    = '0;
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (aluop)
      OP_ADD: begin
        sum    = {1'b0, A} + {1'b0, B};
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = A - B;
        sc_c   = (A >= B);
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:   sc_res = A & B;
      OP_OR:    sc_res = A | B;
      OP_NAND:  sc_res = ~(A & B);
      OP_XOR:   sc_res = A ^ B;
      OP_LSL:   sc_res = A << shamt;
      OP_LSR:   sc_res = A >> shamt;
      OP_PASSB: sc_res = B;
      OP_ASR:   sc_res = $signed(A) >>> shamt;
      default:  sc_res = '0;
    endcase
  end

  // One iteration step; the final step's outputs feed the result directly so
  // the last iteration and the result write share an edge.
  always_comb begin
    acc_nx  = opb_q[0] ? (acc_q + opa_q) : acc_q;
    rem_sh  = {rem_q, opa_q[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, opb_q});
    diff    = rem_sh[WIDTH-1:0] - opb_q;
    rem_nx  = div_ge ? diff : rem_sh[WIDTH-1:0];
    quo_nx  = {opa_q[WIDTH-2:0], div_ge};
    fin_res = is_div_q ? quo_nx : acc_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      is_div_q <= (aluop == OP_UDIV);
      dz_q     <= (B == '0);
      opa_q    <= A;
      opb_q    <= B;
      acc_q    <= '0;
      rem_q    <= '0;
      if (!multi) begin
        result_q <= sc_res;
        z_q      <= (sc_res == '0);
        n_q      <= sc_res[WIDTH-1];
        c_q      <= sc_c;
        v_q      <= sc_v;
      end
    end else if (state_q == S_BUSY) begin
      cnt_q <= cnt_q + 1'b1;
      if (is_div_q) begin
        rem_q <= rem_nx;
        opa_q <= quo_nx;
      end else begin
        acc_q <= acc_nx;
        opa_q <= opa_q << 1;
        opb_q <= opb_q >> 1;
      end
      if (last) begin
        result_q <= fin_res;
        z_q      <= (fin_res == '0);
        n_q      <= fin_res[WIDTH-1];
        c_q      <= 1'b0;
        v_q      <= is_div_q && dz_q;
      end
    end
  end

  assign result = result_q;
  assign Z      = z_q;
  assign N      = n_q;
  assign C      = c_q;
  assign V      = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: runs the same scenarios on a 64-bit and a 32-bit instance.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset, iv, ordy, sel32;
  logic [63:0] a, b;
  logic [5:0]  sh;
  logic [3:0]  op;

  logic        ir64, ov64, z64, n64, c64, v64;
  logic [63:0] res64;
  logic        ir32, ov32, z32, n32, c32, v32;
  logic [31:0] res32;

  logic        ir, ov;
  logic [63:0] res;
  logic [3:0]  fl;

  int          total = 0;
  int          bad   = 0;
  int          w;
  logic [63:0] mask, msb;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(64)) u_alu64 (
    .clk(clk), .reset(reset), .in_valid(iv & ~sel32), .in_ready(ir64),
    .A(a), .B(b), .shamt(sh), .aluop(op),
    .out_valid(ov64), .out_ready(ordy), .result(res64),
    .Z(z64), .N(n64), .C(c64), .V(v64)
  );

  seq_alu #(.WIDTH(32)) u_alu32 (
    .clk(clk), .reset(reset), .in_valid(iv & sel32), .in_ready(ir32),
    .A(a[31:0]), .B(b[31:0]), .shamt(sh[4:0]), .aluop(op),
    .out_valid(ov32), .out_ready(ordy), .result(res32),
    .Z(z32), .N(n32), .C(c32), .V(v32)
  );

  always_comb begin
    ir  = sel32 ? ir32 : ir64;
    ov  = sel32 ? ov32 : ov64;
    res = sel32 ? {32'h0, res32} : res64;
    fl  = sel32 ? {z32, n32, c32, v32} : {z64, n64, c64, v64};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (w=%0d): got=%h expected=%h", tag, w, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, measure latency, check, then handshake.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] ia,
                        input logic [63:0] ib, input logic [5:0] s,
                        input logic [63:0] er, input logic [3:0] ef, input int elat);
    int lat;
    logic busy_ok;
    check({tag, "/in_ready"}, 64'(ir), 64'd1);
    op = o; a = ia; b = ib; sh = s; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; a = ~ia; b = ib ^ 64'h5A5A_A5A5_0F0F_F0F0; op = 4'd12; sh = ~s;
    lat = 1;
    busy_ok = 1'b1;
    while (!ov && lat < 200) begin
      if (ir) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(elat));
    check({tag, "/busy_rdy"}, 64'(busy_ok), 64'd1);
    check({tag, "/done_rdy"}, 64'(ir), 64'd0);
    check({tag, "/result"}, res, er);
    check({tag, "/flags"}, 64'(fl), 64'(ef));
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, "/ov_drop"}, 64'(ov), 64'd0);
    check({tag, "/idle_rdy"}, 64'(ir), 64'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; iv = 1'b0; ordy = 1'b0; sel32 = 1'b0;
    a = '0; b = '0; sh = '0; op = '0;
    for (int pass = 0; pass < 2; pass++) begin
      sel32 = (pass == 1);
      w     = sel32 ? 32 : 64;
      mask  = sel32 ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      msb   = 64'd1 << (w - 1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset/result", res, 64'd0);
      check("reset/flags", 64'(fl), 64'd0);
      check("reset/out_valid", 64'(ov), 64'd0);
      check("reset/in_ready", 64'(ir), 64'd1);

      // flags are {Z,N,C,V}
      run_op("add_ovf",   4'd0,  msb - 1, 64'd1,    6'd0, msb,      4'b0101, 1);
      run_op("add_carry", 4'd0,  mask,    64'd1,    6'd0, 64'd0,    4'b1010, 1);
      run_op("sub_eq",    4'd1,  64'd5,   64'd5,    6'd0, 64'd0,    4'b1010, 1);
      run_op("sub_neg",   4'd1,  64'd3,   64'd5,    6'd0, mask - 1, 4'b0100, 1);
      run_op("sub_ovf",   4'd1,  msb,     64'd1,    6'd0, msb - 1,  4'b0011, 1);
      run_op("and",       4'd2,  64'hF0F0, 64'hFF00, 6'd0, 64'hF000, 4'b0000, 1);
      run_op("or",        4'd3,  64'hF0F0, 64'hFF00, 6'd0, 64'hFFF0, 4'b0000, 1);
      run_op("nand",      4'd4,  mask,    mask,     6'd0, 64'd0,    4'b1000, 1);
      run_op("lsl",       4'd6,  64'd1,   64'd0,    6'(w - 1), msb, 4'b0100, 1);
      run_op("lsr",       4'd7,  msb,     64'd0,    6'(w - 1), 64'd1, 4'b0000, 1);
      run_op("passb",     4'd8,  64'd7,   msb,      6'd0, msb,      4'b0100, 1);
      run_op("reserved",  4'd13, 64'd5,   64'd7,    6'd0, 64'd0,    4'b1000, 1);
      run_op("mul",       4'd10, 64'd3,   mask - 1, 6'd0, mask - 5, 4'b0100, w + 1);
      run_op("udiv",      4'd11, 64'd100, 64'd7,    6'd0, 64'd14,   4'b0000, w + 1);
      run_op("udiv_dz",   4'd11, 64'd9,   64'd0,    6'd0, mask,     4'b0101, w + 1);

      // backpressure: hold DONE for 5 cycles while inputs wander
      op = 4'd5; a = 64'hF0; b = 64'hFF; sh = '0; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      for (int i = 0; i < 5; i++) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        check("bp/out_valid", 64'(ov), 64'd1);
        check("bp/in_ready", 64'(ir), 64'd0);
        check("bp/result", res, 64'h0F);
        check("bp/flags", 64'(fl), 64'd0);
        @(posedge clk); #1;
      end
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      check("bp/ov_drop", 64'(ov), 64'd0);

      // reset in the middle of a multiply
      op = 4'd10; a = 64'd3; b = 64'd5; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      check("rst_mid/busy_rdy", 64'(ir), 64'd0);
      reset = 1'b1;
      #1;
      check("rst_mid/async_rdy", 64'(ir), 64'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid/out_valid", 64'(ov), 64'd0);
      check("rst_mid/in_ready", 64'(ir), 64'd1);
      check("rst_mid/result", res, 64'd0);
      run_op("asr", 4'd9, msb, 64'd0, 6'(w - 1), mask, 4'b0100, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
